// File: rtl/rst_sequencer.sv
// Staged reset-release sequencer: releases uncore, then periph, then core after a
// programmable hold, re-runs on watchdog/software requests and core-only on ndmreset.
`timescale 1ns/1ps
module rst_sequencer #(
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wdt_rst_req,
   input  logic       sw_rst_req,
   input  logic       ndm_rst_req,
   output logic       rst_uncore_n,
   output logic       rst_periph_n,
   output logic       rst_core_n,
   output logic       sys_ready,
   output logic [3:0] rst_cause
);

   typedef enum logic [2:0] {
      S_RESET,
      S_HOLD,
      S_REL_UNCORE,
      S_REL_PERIPH,
      S_RUN,
      S_CORE_HOLD
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

   state_t     r_state;
   state_t     w_stateNext;
   logic [7:0] r_cnt;
   logic [7:0] w_cntNext;
   logic       r_uncoreN;
   logic       r_periphN;
   logic       r_coreN;
   logic       r_ready;
   logic [3:0] r_cause;
   logic       w_uncoreN;
   logic       w_periphN;
   logic       w_coreN;
   logic [3:0] w_causeNext;

   // State, counter and all outputs are registered; rst_n low overrides everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_RESET;
         r_cnt     <= 8'd0;
         r_uncoreN <= 1'b0;
         r_periphN <= 1'b0;
         r_coreN   <= 1'b0;
         r_ready   <= 1'b0;
         r_cause   <= 4'b0001;
      end else begin
         r_state   <= w_stateNext;
         r_cnt     <= w_cntNext;
         r_uncoreN <= w_uncoreN;
         r_periphN <= w_periphN;
         r_coreN   <= w_coreN;
         r_ready   <= w_coreN;
         r_cause   <= w_causeNext;
      end
   end

   // RESET counts like HOLD once rst_n is high, so edge 1 is the first hold cycle.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_RESET, S_HOLD: if (r_cnt == HOLD_LAST) w_stateNext = S_REL_UNCORE;
         S_REL_UNCORE:    if (r_cnt == STEP_LAST) w_stateNext = S_REL_PERIPH;
         S_REL_PERIPH:    if (r_cnt == STEP_LAST) w_stateNext = S_RUN;
         S_RUN: begin
            if (wdt_rst_req || sw_rst_req) w_stateNext = S_HOLD;
            else if (ndm_rst_req)          w_stateNext = S_CORE_HOLD;
         end
         S_CORE_HOLD:     if (r_cnt == HOLD_LAST) w_stateNext = S_RUN;
         default:         w_stateNext = S_RESET;
      endcase
      w_cntNext = (w_stateNext != r_state || r_state == S_RUN) ? 8'd0 : r_cnt + 8'd1;
   end

   always_comb begin
      w_uncoreN   = (w_stateNext == S_REL_UNCORE) || (w_stateNext == S_REL_PERIPH) ||
                    (w_stateNext == S_RUN) || (w_stateNext == S_CORE_HOLD);
      w_periphN   = (w_stateNext == S_REL_PERIPH) || (w_stateNext == S_RUN) ||
                    (w_stateNext == S_CORE_HOLD);
      w_coreN     = (w_stateNext == S_RUN);
      w_causeNext = r_cause;
      if (r_state == S_RUN) begin
         if (wdt_rst_req)      w_causeNext = 4'b0010;
         else if (sw_rst_req)  w_causeNext = 4'b0100;
         else if (ndm_rst_req) w_causeNext = 4'b1000;
      end
   end

   assign rst_uncore_n = r_uncoreN;
   assign rst_periph_n = r_periphN;
   assign rst_core_n   = r_coreN;
   assign sys_ready    = r_ready;
   assign rst_cause    = r_cause;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: a default instance and a HOLD=1/STEP=1 instance,
// expected outputs derived from the release-latency formulas and queued per edge.
`timescale 1ns/1ps
module tb_rst_sequencer;

   localparam int A_HOLD = 16;
   localparam int A_STEP = 8;
   localparam int B_HOLD = 1;
   localparam int B_STEP = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       aRstN, aWdt, aSw, aNdm;
   logic       aUnc, aPer, aCore, aRdy;
   logic [3:0] aCause;
   logic       bRstN, bWdt, bSw, bNdm;
   logic       bUnc, bPer, bCore, bRdy;
   logic [3:0] bCause;

   rst_sequencer #(.HOLD_CYCLES(A_HOLD), .STEP_CYCLES(A_STEP)) dutA (
      .clk(clk), .rst_n(aRstN), .wdt_rst_req(aWdt), .sw_rst_req(aSw), .ndm_rst_req(aNdm),
      .rst_uncore_n(aUnc), .rst_periph_n(aPer), .rst_core_n(aCore), .sys_ready(aRdy),
      .rst_cause(aCause)
   );

   rst_sequencer #(.HOLD_CYCLES(B_HOLD), .STEP_CYCLES(B_STEP)) dutB (
      .clk(clk), .rst_n(bRstN), .wdt_rst_req(bWdt), .sw_rst_req(bSw), .ndm_rst_req(bNdm),
      .rst_uncore_n(bUnc), .rst_periph_n(bPer), .rst_core_n(bCore), .sys_ready(bRdy),
      .rst_cause(bCause)
   );

   typedef struct packed {
      logic       unc;
      logic       per;
      logic       core;
      logic       rdy;
      logic [3:0] cause;
   } outs_t;

   typedef struct packed {
      outs_t a;
      outs_t b;
   } exp_t;

   typedef struct {
      string      name;
      logic       wdt;
      logic       sw;
      logic       ndm;
      logic [3:0] expCause;
      int         settle;
   } scen_t;

   exp_t       sbQueue[$];
   int         total = 0;
   int         bad = 0;

   // Model: mode 0 = held in reset, 1 = full sequence k edges in, 2 = core-only k edges in.
   int         aMode = 0, aK = 0, bMode = 0, bK = 0;
   logic [3:0] aExpCause = 4'b0001, bExpCause = 4'b0001;

   function automatic outs_t expectOut(input int mode, input int k, input int hold,
                                       input int step, input logic [3:0] cause);
      outs_t o;
      o.cause = cause;
      o.unc   = 1'b0;
      o.per   = 1'b0;
      o.core  = 1'b0;
      if (mode == 1) begin
         o.unc  = (k >= hold);
         o.per  = (k >= hold + step);
         o.core = (k >= hold + 2 * step);
      end else if (mode == 2) begin
         o.unc  = 1'b1;
         o.per  = 1'b1;
         o.core = (k >= hold);
      end
      o.rdy = o.core;
      return o;
   endfunction

   task automatic advanceModel(input logic rstN, input logic wdt, input logic sw,
                               input logic ndm, input int hold, input int step,
                               inout int mode, inout int k, inout logic [3:0] cause);
      outs_t prev;
      prev = expectOut(mode, k, hold, step, cause);
      if (!rstN) begin
         mode = 0; k = 0; cause = 4'b0001;
      end else if (mode == 0) begin
         mode = 1; k = 1;
      end else if (prev.rdy && wdt) begin
         mode = 1; k = 0; cause = 4'b0010;
      end else if (prev.rdy && sw) begin
         mode = 1; k = 0; cause = 4'b0100;
      end else if (prev.rdy && ndm) begin
         mode = 2; k = 0; cause = 4'b1000;
      end else if (k < 10000) begin
         k = k + 1;
      end
   endtask

   task automatic checkOutput();
      exp_t  e;
      outs_t actA, actB;
      if (sbQueue.size() == 0) begin
         total++; bad++;
         $display("[TB] FAIL scoreboard: queue empty, got nothing required one entry");
         return;
      end
      e    = sbQueue.pop_front();
      actA = {aUnc, aPer, aCore, aRdy, aCause};
      actB = {bUnc, bPer, bCore, bRdy, bCause};
      total++;
      if (actA !== e.a) begin
         bad++;
         $display("[TB] FAIL dutA t=%0t: got unc/per/core/rdy/cause=%b required %b",
                  $time, actA, e.a);
      end
      total++;
      if (actB !== e.b) begin
         bad++;
         $display("[TB] FAIL dutB t=%0t: got unc/per/core/rdy/cause=%b required %b",
                  $time, actB, e.b);
      end
   endtask

   // Inputs are already set for this edge: push what the edge should produce, then sample.
   task automatic applyStimulus();
      exp_t e;
      advanceModel(aRstN, aWdt, aSw, aNdm, A_HOLD, A_STEP, aMode, aK, aExpCause);
      advanceModel(bRstN, bWdt, bSw, bNdm, B_HOLD, B_STEP, bMode, bK, bExpCause);
      e.a = expectOut(aMode, aK, A_HOLD, A_STEP, aExpCause);
      e.b = expectOut(bMode, bK, B_HOLD, B_STEP, bExpCause);
      sbQueue.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %b required %b", name, act, req);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      scen_t scenTab[4];
      scenTab[0] = '{"wdt",         1'b1, 1'b0, 1'b0, 4'b0010, 36};
      scenTab[1] = '{"wdt+sw+ndm",  1'b1, 1'b1, 1'b1, 4'b0010, 36};
      scenTab[2] = '{"sw+ndm",      1'b0, 1'b1, 1'b1, 4'b0100, 36};
      scenTab[3] = '{"ndm",         1'b0, 1'b0, 1'b1, 4'b1000, 20};

      aRstN = 1'b0; aWdt = 1'b0; aSw = 1'b0; aNdm = 1'b0;
      bRstN = 1'b0; bWdt = 1'b0; bSw = 1'b0; bNdm = 1'b0;

      // Power-on reset: five low edges, then release both instances together
      repeat (5) applyStimulus();
      checkValue("por cause", {4'd0, aCause}, 8'b0000_0001);
      aRstN = 1'b1;
      bRstN = 1'b1;
      repeat (36) applyStimulus();
      checkValue("por run", {4'd0, aUnc, aPer, aCore, aRdy}, 8'b0000_1111);

      for (int i = 0; i < 4; i++) begin
         aWdt = scenTab[i].wdt;
         aSw  = scenTab[i].sw;
         aNdm = scenTab[i].ndm;
         applyStimulus();
         aWdt = 1'b0; aSw = 1'b0; aNdm = 1'b0;
         checkValue({scenTab[i].name, " cause"}, {4'd0, aCause}, {4'd0, scenTab[i].expCause});
         repeat (scenTab[i].settle) applyStimulus();
      end

      // Software request raised during REL_UNCORE must wait for the first RUN edge
      aWdt = 1'b1;
      applyStimulus();
      aWdt = 1'b0;
      repeat (18) applyStimulus();
      aSw = 1'b1;
      for (int i = 0; i < 40 && aSw; i++) begin
         applyStimulus();
         if (aMode == 1 && aK == 0) aSw = 1'b0;
      end
      checkValue("sw held cause", {4'd0, aCause}, 8'b0000_0100);
      checkValue("sw held resets", {4'd0, aUnc, aPer, aCore, aRdy}, 8'b0000_0000);
      repeat (36) applyStimulus();

      // rst_n dropping during REL_PERIPH restarts everything as POR
      aWdt = 1'b1;
      applyStimulus();
      aWdt = 1'b0;
      repeat (26) applyStimulus();
      aRstN = 1'b0;
      applyStimulus();
      checkValue("midseq por", {aCause, aUnc, aPer, aCore, aRdy}, 8'b0001_0000);
      applyStimulus();
      aRstN = 1'b1;
      repeat (36) applyStimulus();

      // Minimum-parameter instance: full and core-only re-runs
      bWdt = 1'b1;
      applyStimulus();
      bWdt = 1'b0;
      checkValue("fast wdt cause", {4'd0, bCause}, 8'b0000_0010);
      repeat (5) applyStimulus();
      bNdm = 1'b1;
      applyStimulus();
      bNdm = 1'b0;
      checkValue("fast ndm", {bCause, bUnc, bPer, bCore, bRdy}, 8'b1000_1100);
      repeat (4) applyStimulus();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
